streamlined_multiplier_8bit: RTL and testbench
==============================================

# streamlined_multiplier_8bit

Multi-cycle 8x8 shift-add multiplier that produces a 16-bit product. It is the inverse-operation partner of the team's 8-bit streamlined divider. It uses the same `start_sig` / `done_sig` request handshake, so one sequencer can drive both blocks interchangeably. It sits beside the divider in the arithmetic datapath and is fed by the same requester FSMs.

## Interface
Parameters: none. Widths are fixed and held in the package.

Ports:
- `clk`  in  1  single clock, rising-edge
- `rst`  in  1  asynchronous, active-high reset
- `start_sig`  in  1  request; held high by the requester until it samples `done_sig`
- `multiplicand`  in  8  operand A, two's complement (see Configuration)
- `multiplier`  in  8  operand B, two's complement (see Configuration)
- `done_sig`  out  1  one-cycle completion pulse
- `busy`  out  1  high from operand capture until the `DONE` state is left
- `product`  out  16  result; holds its value until the next completion

## Operation
- States:
  - `IDLE`
  - `CALC` (8 iterations)
  - `FIX` (sign apply)
  - `DONE`
- `IDLE`: when `start_sig`=1 at an edge:
  - latch sign = A[7]^B[7];
  - latch |A| and |B| as 8-bit unsigned magnitudes (|-128| = 128 fits);
  - clear the 16-bit accumulator and the 3-bit counter;
  - go to `CALC`.
- `CALC`: each cycle, if the multiplier-magnitude LSB is 1, add the shifted multiplicand magnitude to the accumulator. Then shift the multiplicand magnitude left and the multiplier magnitude right. After the 8th iteration (counter wraps 7→0), go to `FIX`.
- `FIX`:
  - `product` <= sign ? -acc : acc (16-bit two's complement);
  - `done_sig` <= 1;
  - go to `DONE`.
- `DONE`: `done_sig` <= 0 and go to `IDLE` unconditionally. The value of `start_sig` is not examined in this state.
- Operands and `start_sig` are ignored outside `IDLE`. Operand changes mid-operation do not affect the result.
- Deasserting `start_sig` mid-operation does not abort the operation; `done_sig` still pulses.
- Range: the magnitude product is at most 16384, so no overflow is possible. -128 x -128 = +16384 (0x4000).

## Timing
- Reset values: `done_sig`=0, `busy`=0, `product`=16'h0000, state=`IDLE`, all internal registers 0.
- Reset asserted mid-operation: `IDLE` is entered immediately (asynchronously). No `done_sig` is produced. `product` is cleared to 0.
- Latency: with `start_sig` sampled high at edge E0, `done_sig` and the new `product` are visible after edge E9. `done_sig` is high for exactly one cycle and falls after E10.
- Throughput: one operation per 11 cycles when the requester drops `start_sig` on the edge at which it sees `done_sig`.
  - At that edge (E10) the block is in `DONE` and ignores `start_sig`.
  - At E11 the block is in `IDLE` and samples the requester's next request.
- `busy` rises after E0 and falls after E10.
- `product` changes only at the `FIX` edge.

## Configuration
- Macro: `STREAMLINED_MUL_SIGNED_EN`.
- Defined: operands are two's complement and the sign correction described above applies.
- Undefined: operands are unsigned and the magnitude is the operand itself. `FIX` passes the accumulator through unchanged, so 255 x 255 = 65025 (0xFE01).
- Latency is identical in both builds. `FIX` is always present.

## Structure
- Package `streamlined_arith_pkg`, shared with the divider, holds:
  - operand width constant (8) and product width constant (16);
  - iteration count (8);
  - state enum typedef (`IDLE` / `CALC` / `FIX` / `DONE`).
- Sub-module `sign_mag_conv`: combinational 8-bit two's complement to sign plus magnitude conversion, instantiated twice. The divider reuses it.

## Test plan
1. Reset, then request 7 x 2 with `start_sig` held → `done_sig` pulses after 10 edges; `product`=0x000E; `busy` is high for 10 cycles.
2. Back-to-back requests 8 x -3, then -19 x 6, then -120 x -7 from a requester that drops `start_sig` on `done_sig` → `product` = 0xFFE8, then 0xFF8E, then 0x0348. Each operation completes exactly once, with no double start.
3. Corner cases -128 x -128, -128 x 127 and 0 x -5 → `product` = 0x4000, 0xC080 and 0x0000 respectively.
4. Start 100 x 3, then change the operands to 1 x 1 and drop `start_sig` during `CALC` → `product`=0x012C, and `done_sig` still pulses once.
5. Assert `rst` during `CALC` of 50 x 50 → `product`=0, `busy`=0, no `done_sig`. A subsequent 5 x 5 returns 0x0019.
6. Build without `STREAMLINED_MUL_SIGNED_EN`: 255 x 255 → 0xFE01, and 0xFD x 0x08 → 0x07E8, both with the same 10-edge latency.

Source files
------------

// File: rtl/streamlined_arith_pkg.sv
// Shared widths, iteration count and sequencing states for the streamlined
// multiplier and divider datapath blocks.
package streamlined_arith_pkg;

    localparam int unsigned OP_W   = 8;
    localparam int unsigned PROD_W = 16;
    localparam int unsigned ITER_N = 8;
    localparam int unsigned CNT_W  = $clog2(ITER_N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/streamlined_multiplier_8bit_if.sv
// Request/response bundle between a requester FSM and the multiplier.
// The requester holds start_sig until it samples the done_sig pulse.
interface streamlined_multiplier_8bit_if;
    import streamlined_arith_pkg::*;

    logic              start_sig;
    logic [OP_W-1:0]   multiplicand;
    logic [OP_W-1:0]   multiplier;
    logic              done_sig;
    logic              busy;
    logic [PROD_W-1:0] product;

    modport master (
        output start_sig, multiplicand, multiplier,
        input  done_sig, busy, product
    );

    modport slave (
        input  start_sig, multiplicand, multiplier,
        output done_sig, busy, product
    );
endinterface

// File: rtl/sign_mag_conv.sv
// Combinational 8-bit two's complement to sign plus magnitude.
// -128 maps to magnitude 128, which still fits the unsigned 8-bit output.
module sign_mag_conv
    import streamlined_arith_pkg::*;
(
    input  logic [OP_W-1:0] val_i,
    output logic            sign_o,
    output logic [OP_W-1:0] mag_o
);

    // Negate only when the sign bit is set.
    always_comb begin
        sign_o = val_i[OP_W-1];
        mag_o  = val_i[OP_W-1] ? (~val_i + {{(OP_W-1){1'b0}}, 1'b1}) : val_i;
    end

endmodule

// File: rtl/streamlined_multiplier_8bit.sv
// 8x8 shift-add multiplier, 16-bit product, start_sig/done_sig handshake.
// Build option STREAMLINED_MUL_SIGNED_EN: when defined, operands are two's
// complement and FIX applies the sign; otherwise operands are unsigned and
// FIX passes the accumulator through. Latency is the same in both builds.
//
// state | meaning
// IDLE  | waiting for start_sig, operands captured on request
// CALC  | eight shift-add iterations on the magnitudes
// FIX   | sign applied, product and done_sig registered
// DONE  | done_sig dropped, back to IDLE without looking at start_sig
module streamlined_multiplier_8bit
    import streamlined_arith_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    streamlined_multiplier_8bit_if.slave bus
);

    state_t            state_q;
    logic [PROD_W-1:0] acc_q;
    logic [PROD_W-1:0] acc_d;
    logic [PROD_W-1:0] mcand_q;
    logic [OP_W-1:0]   mplier_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [PROD_W-1:0] product_q;
    logic [PROD_W-1:0] product_d;
    logic              done_q;
    logic              busy_q;
    logic [OP_W-1:0]   mag_a;
    logic [OP_W-1:0]   mag_b;

`ifdef STREAMLINED_MUL_SIGNED_EN
    logic sign_a;
    logic sign_b;
    logic sign_q;

    sign_mag_conv u_conv_a (
        .val_i  (bus.multiplicand),
        .sign_o (sign_a),
        .mag_o  (mag_a)
    );

    sign_mag_conv u_conv_b (
        .val_i  (bus.multiplier),
        .sign_o (sign_b),
        .mag_o  (mag_b)
    );

    // Accumulate step and sign-corrected result.
    always_comb begin
        acc_d     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        product_d = sign_q ? (~acc_q + {{(PROD_W-1){1'b0}}, 1'b1}) : acc_q;
    end
`else
    assign mag_a = bus.multiplicand;
    assign mag_b = bus.multiplier;

    // Accumulate step; unsigned result needs no correction.
    always_comb begin
        acc_d     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        product_d = acc_q;
    end
`endif

    // Sequencer with registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
`ifdef STREAMLINED_MUL_SIGNED_EN
            sign_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start_sig) begin
`ifdef STREAMLINED_MUL_SIGNED_EN
                        sign_q   <= sign_a ^ sign_b;
`endif
                        mcand_q  <= {{(PROD_W-OP_W){1'b0}}, mag_a};
                        mplier_q <= mag_b;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= CALC;
                    end
                end
                CALC: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_q == CNT_W'(ITER_N - 1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    product_q <= product_d;
                    done_q    <= 1'b1;
                    state_q   <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.done_sig = done_q;
    assign bus.busy     = busy_q;
    assign bus.product  = product_q;

endmodule

// File: tb/tb_streamlined_multiplier_8bit.sv
// Self-checking bench for streamlined_multiplier_8bit. Expected products are
// computed with the native multiply operator, following the same
// STREAMLINED_MUL_SIGNED_EN setting as the design build.
module tb_streamlined_multiplier_8bit;
    import streamlined_arith_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   passes;
    logic [15:0] exp_q[$];

    streamlined_multiplier_8bit_if bus();

    streamlined_multiplier_8bit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] model_product(input logic [7:0] a, input logic [7:0] b);
`ifdef STREAMLINED_MUL_SIGNED_EN
        logic signed [15:0] sa;
        logic signed [15:0] sb;
        logic signed [15:0] p;
        sa = $signed({{8{a[7]}}, a});
        sb = $signed({{8{b[7]}}, b});
        p  = sa * sb;
        return p;
`else
        return {8'h00, a} * {8'h00, b};
`endif
    endfunction

    // Drives one request, pushes its expected result, waits for done_sig and
    // one more edge; then watches tail extra edges for stray pulses.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit drop_mid,
                          input int tail, output int done_edge, output int busy_cyc,
                          output int done_cnt, output logic [15:0] prod);
        bus.start_sig    = 1'b1;
        bus.multiplicand = a;
        bus.multiplier   = b;
        exp_q.push_back(model_product(a, b));
        done_edge = -1;
        busy_cyc  = 0;
        done_cnt  = 0;
        prod      = 16'hxxxx;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (bus.busy) busy_cyc++;
            if (bus.done_sig) begin
                done_cnt++;
                if (done_edge < 0) begin
                    done_edge = k;
                    prod      = bus.product;
                end
                bus.start_sig = 1'b0;
            end
            if (drop_mid && k == 3) begin
                bus.start_sig    = 1'b0;
                bus.multiplicand = 8'd1;
                bus.multiplier   = 8'd1;
            end
            if (done_edge >= 0 && k == done_edge + 1) break;
        end
        bus.start_sig = 1'b0;
        for (int k = 0; k < tail; k++) begin
            @(posedge clk);
            #1;
            if (bus.done_sig) done_cnt++;
            if (bus.busy) busy_cyc++;
        end
    endtask

    task automatic test_reset();
        checks++;
        if (bus.done_sig !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done_sig);
        else passes++;
        checks++;
        if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy);
        else passes++;
        checks++;
        if (bus.product !== 16'h0000) $display("FAIL reset_product got %h want 0000", bus.product);
        else passes++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b0) $display("FAIL idle_busy got %b want 0", bus.busy);
        else passes++;
    endtask

    task automatic test_basic();
        int de, bc, dc;
        logic [15:0] p, e;
        run_op(8'd7, 8'd2, 1'b0, 3, de, bc, dc, p);
        e = exp_q.pop_front();
        checks++;
        if (de !== 10) $display("FAIL basic_latency got %0d edges want 10", de);
        else passes++;
        checks++;
        if (p !== e) $display("FAIL basic_product got %h want %h", p, e);
        else passes++;
        checks++;
        if (bc !== 10) $display("FAIL basic_busy_cycles got %0d want 10", bc);
        else passes++;
        checks++;
        if (dc !== 1) $display("FAIL basic_done_count got %0d want 1", dc);
        else passes++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] as [3] = '{8'd8, 8'hED, 8'h88};
        logic [7:0] bs [3] = '{8'hFD, 8'd6, 8'hF9};
        int de, bc, dc;
        logic [15:0] p, e;
        for (int i = 0; i < 3; i++) begin
            run_op(as[i], bs[i], 1'b0, (i == 2) ? 6 : 0, de, bc, dc, p);
            e = exp_q.pop_front();
            checks++;
            if (p !== e) $display("FAIL b2b_product_%0d got %h want %h", i, p, e);
            else passes++;
            checks++;
            if (de !== 10) $display("FAIL b2b_latency_%0d got %0d want 10", i, de);
            else passes++;
            checks++;
            if (dc !== 1) $display("FAIL b2b_done_count_%0d got %0d want 1", i, dc);
            else passes++;
            checks++;
            if (bc !== 10) $display("FAIL b2b_busy_cycles_%0d got %0d want 10", i, bc);
            else passes++;
        end
    endtask

    task automatic test_corners();
        logic [7:0] as [5] = '{8'h80, 8'h80, 8'h00, 8'hFF, 8'hFD};
        logic [7:0] bs [5] = '{8'h80, 8'h7F, 8'hFB, 8'hFF, 8'h08};
        int de, bc, dc;
        logic [15:0] p, e;
        for (int i = 0; i < 5; i++) begin
            run_op(as[i], bs[i], 1'b0, 2, de, bc, dc, p);
            e = exp_q.pop_front();
            checks++;
            if (p !== e) $display("FAIL corner_product_%0d got %h want %h", i, p, e);
            else passes++;
            checks++;
            if (de !== 10) $display("FAIL corner_latency_%0d got %0d want 10", i, de);
            else passes++;
        end
    endtask

    task automatic test_operand_change();
        int de, bc, dc;
        logic [15:0] p, e;
        run_op(8'd100, 8'd3, 1'b1, 5, de, bc, dc, p);
        e = exp_q.pop_front();
        checks++;
        if (p !== e) $display("FAIL opchange_product got %h want %h", p, e);
        else passes++;
        checks++;
        if (dc !== 1) $display("FAIL opchange_done_count got %0d want 1", dc);
        else passes++;
        checks++;
        if (bus.product !== e) $display("FAIL opchange_product_hold got %h want %h", bus.product, e);
        else passes++;
    endtask

    task automatic test_reset_mid_op();
        int stray;
        int de, bc, dc;
        logic [15:0] p, e;
        bus.start_sig    = 1'b1;
        bus.multiplicand = 8'd50;
        bus.multiplier   = 8'd50;
        @(posedge clk);
        #1;
        bus.start_sig = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b1) $display("FAIL midrst_busy_before got %b want 1", bus.busy);
        else passes++;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.product !== 16'h0000) $display("FAIL midrst_product got %h want 0000", bus.product);
        else passes++;
        checks++;
        if (bus.busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", bus.busy);
        else passes++;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        stray = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            #1;
            if (bus.done_sig) stray++;
        end
        checks++;
        if (stray !== 0) $display("FAIL midrst_no_done got %0d pulses want 0", stray);
        else passes++;
        run_op(8'd5, 8'd5, 1'b0, 2, de, bc, dc, p);
        e = exp_q.pop_front();
        checks++;
        if (p !== e) $display("FAIL midrst_after_product got %h want %h", p, e);
        else passes++;
        checks++;
        if (de !== 10) $display("FAIL midrst_after_latency got %0d want 10", de);
        else passes++;
    endtask

    initial begin
        checks           = 0;
        passes           = 0;
        rst              = 1'b1;
        bus.start_sig    = 1'b0;
        bus.multiplicand = 8'h00;
        bus.multiplier   = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_back_to_back();
        test_corners();
        test_operand_change();
        test_reset_mid_op();
        checks++;
        if (exp_q.size() !== 0) $display("FAIL scoreboard_drain got %0d left want 0", exp_q.size());
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
